// File: rtl/mem_responder.sv
// Single-port SRAM responder: one-cycle access, capture, programmable wait, one-cycle response.
// Data-space requests are offset by DATA_BASE with silent address wrap.
module mem_responder #(
    parameter int unsigned                DATA_WIDTH  = 16,
    parameter int unsigned                ADDR_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0]      DATA_BASE   = 8'h80,
    parameter int unsigned                WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_read_not_write,
    input  logic                  req_select,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_WAIT,
        S_RESP
    } state_e;

    localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  rnw_q, rnw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes decode from state so reset kills them without waiting for an edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rnw_d      = rnw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        resp_ready = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (req_valid) begin
                    rnw_d   = req_read_not_write;
                    addr_d  = req_select ? (req_addr + DATA_BASE) : req_addr;
                    wdata_d = req_wdata;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_en  = 1'b1;
                mem_we  = ~rnw_q;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (rnw_q) rdata_d = mem_rdata;
                if (WAIT_STATES > 0) begin
                    cnt_d   = WS_LOAD;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) state_d = S_RESP;
                else cnt_d = cnt_q - 3'd1;
            end
            S_RESP: begin
                resp_ready = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign resp_rdata = rdata_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of the data word.
REQ-002 Parameter ADDR_WIDTH, default 8, width of the word address.
REQ-003 Parameter DATA_BASE, default 8'h80, offset added to data-space addresses.
REQ-004 Parameter WAIT_STATES, default 2, legal 0..7, extra cycles inserted before each response.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 req_valid  input  1  CPU requests a memory access.
REQ-008 req_read_not_write  input  1  1 = read, 0 = write.
REQ-009 req_select  input  1  0 = instruction space, 1 = data space.
REQ-010 req_addr  input  ADDR_WIDTH  CPU word address.
REQ-011 req_wdata  input  DATA_WIDTH  CPU write data.
REQ-012 resp_ready  output  1  one-cycle pulse marking completion.
REQ-013 resp_rdata  output  DATA_WIDTH  registered read data.
REQ-014 busy  output  1  high whenever a request is in flight.
REQ-015 mem_en  output  1  SRAM enable.
REQ-016 mem_we  output  1  SRAM write enable.
REQ-017 mem_addr  output  ADDR_WIDTH  SRAM address.
REQ-018 mem_wdata  output  DATA_WIDTH  SRAM write data.
REQ-019 mem_rdata  input  DATA_WIDTH  SRAM read data, valid the cycle after a read enable.

Function
REQ-020 FSM states: IDLE, ACCESS, CAPTURE, WAIT, RESP; busy=1 in every state except IDLE.
REQ-021 IDLE: on req_valid=1 at the edge, latch rnw/select/addr/wdata and go to ACCESS; otherwise stay.
REQ-022 Requests are accepted only in IDLE; req_* changes while busy are ignored.
REQ-023 Latched address: select=0 -> req_addr; select=1 -> (req_addr + DATA_BASE) mod 2^ADDR_WIDTH, with wrap and no error.
REQ-024 ACCESS (exactly 1 cycle): mem_en=1, mem_we=~rnw, mem_addr/mem_wdata = latched values; next state CAPTURE.
REQ-025 mem_en and mem_we are 0 in every state other than ACCESS; mem_addr/mem_wdata hold their last latched values.
REQ-026 CAPTURE (1 cycle): for a read, resp_rdata <= mem_rdata at the ending edge; for a write, resp_rdata is unchanged; next state WAIT if WAIT_STATES>0, else RESP.
REQ-027 WAIT: a 3-bit counter loads WAIT_STATES-1 on entry and decrements each cycle; at 0 go to RESP (exactly WAIT_STATES cycles).
REQ-028 RESP (1 cycle): resp_ready=1; next state IDLE unconditionally.
REQ-029 Latency: request accepted at edge E0 -> resp_ready high during cycle 3+WAIT_STATES after E0 (ACCESS = cycle 1).
REQ-030 Back-to-back: a req_valid held through RESP is accepted at the first edge in IDLE; minimum issue interval is 4+WAIT_STATES cycles.
REQ-031 resp_rdata holds its value until the next read CAPTURE.
REQ-032 Writes and reads use identical latency and identical state sequences.

Reset
REQ-033 reset=0 asynchronously forces IDLE, counter=0, resp_ready=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, resp_rdata=0.
REQ-034 Reset mid-operation aborts the access with no response; mem_we drops immediately even during ACCESS.
REQ-035 After release, the first rising edge with req_valid=1 is accepted normally.

Verification
REQ-036 Read, WAIT_STATES=2, select=0, addr=8'h05, SRAM[05]=16'hBEEF -> mem_en pulse at addr 05 in cycle 1; resp_ready in cycle 5; resp_rdata=16'hBEEF.
REQ-037 Write, select=1, addr=8'h10, wdata=16'h1234 -> mem_we=1 at mem_addr 8'h90 for exactly one cycle; resp_ready in cycle 5; resp_rdata unchanged.
REQ-038 Wrap: select=1, addr=8'hF0 -> mem_addr=8'h70.
REQ-039 WAIT_STATES=0, read -> resp_ready in cycle 3; WAIT never entered.
REQ-040 req_valid held high across two requests with addr changed mid-flight from 01 to 02 -> first access uses 01, second uses 02, issued 4+WAIT_STATES cycles after the first.
REQ-041 reset=0 asserted during ACCESS of a write -> mem_we=0 immediately; no resp_ready; busy=0; the next request completes normally.
